// File: rtl/ex_issue_stage_pkg.sv
// ex_issue_stage_pkg
//   Shared widths, ALU function codes and the forward-select type used by the
//   issue stage, its operand mux and the surrounding pipeline.
package ex_issue_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] OP_NOP = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwdSel_e;

endpackage

// File: rtl/ex_issue_stage_if.sv
// ex_issue_stage_if
//   Bundles every non-clock, non-reset signal of the issue stage.
//   slave  : the issue stage's view (decode and forwarding inputs, EX outputs)
//   master : the environment's view (drives decode/forwarding, observes EX)
interface ex_issue_stage_if;
  import ex_issue_stage_pkg::*;

  // decode side
  logic              id_valid;
  logic              id_ready;
  logic [OP_W-1:0]   id_op;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;

  // forwarding sources
  logic              ex_mem_reg_write;
  logic              ex_mem_mem_read;
  logic [REG_W-1:0]  ex_mem_rd;
  logic [DATA_W-1:0] ex_mem_result;
  logic              mem_wb_reg_write;
  logic [REG_W-1:0]  mem_wb_rd;
  logic [DATA_W-1:0] mem_wb_data;

  // EX side
  logic              ex_ready;
  logic              ex_valid;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [31:0]       stall_count;

  modport slave (
    input  id_valid, id_op, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_use_imm, id_reg_write, id_mem_read, flush,
           ex_mem_reg_write, ex_mem_mem_read, ex_mem_rd, ex_mem_result,
           mem_wb_reg_write, mem_wb_rd, mem_wb_data, ex_ready,
    output id_ready, ex_valid, alu_a, alu_b, alu_op, ex_rd, ex_reg_write,
           ex_mem_read, stall_count
  );

  modport master (
    output id_valid, id_op, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_use_imm, id_reg_write, id_mem_read, flush,
           ex_mem_reg_write, ex_mem_mem_read, ex_mem_rd, ex_mem_result,
           mem_wb_reg_write, mem_wb_rd, mem_wb_data, ex_ready,
    input  id_ready, ex_valid, alu_a, alu_b, alu_op, ex_rd, ex_reg_write,
           ex_mem_read, stall_count
  );
endinterface

// File: rtl/ex_issue_stage_operand_forward_mux.sv
// operand_forward_mux
//   Picks the newest value of one ALU operand.
//   storedVal/srcReg : operand latched at issue and its source register
//   enable           : operand is register-sourced (cleared for immediates)
//   exMem* / memWb*  : results of the two younger-than-regfile producers
//   value / sel      : resolved operand and which source supplied it
module operand_forward_mux
  import ex_issue_stage_pkg::*;
(
  input  logic [DATA_W-1:0] storedVal,
  input  logic [REG_W-1:0]  srcReg,
  input  logic              enable,
  input  logic              exMemRegWrite,
  input  logic              exMemMemRead,
  input  logic [REG_W-1:0]  exMemRd,
  input  logic [DATA_W-1:0] exMemResult,
  input  logic              memWbRegWrite,
  input  logic [REG_W-1:0]  memWbRd,
  input  logic [DATA_W-1:0] memWbData,
  output logic [DATA_W-1:0] value,
  output fwdSel_e           sel
);

  logic exMemHit;
  logic memWbHit;

  // A load in EX/MEM has no data yet, so it can never be a forward source;
  // the hazard logic upstream guarantees we never need it. Register 0 is
  // hard-wired and is never forwarded.
  assign exMemHit = enable && exMemRegWrite && !exMemMemRead &&
                    (exMemRd != '0) && (exMemRd == srcReg);
  assign memWbHit = enable && memWbRegWrite &&
                    (memWbRd != '0) && (memWbRd == srcReg);

  always_comb begin
    value = storedVal;
    sel   = FWD_NONE;
    if (exMemHit) begin
      value = exMemResult;
      sel   = FWD_EXMEM;
    end else if (memWbHit) begin
      value = memWbData;
      sel   = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ex_issue_stage
//   ID/EX pipeline register feeding the ALU. Latches one decoded instruction,
//   forwards operands from EX/MEM and MEM/WB, inserts one bubble per load-use
//   hazard, holds under EX back-pressure and empties on flush.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ex_issue_stage_if.slave (decode handshake, forwarding, EX outputs)
module ex_issue_stage
  import ex_issue_stage_pkg::*;
(
  input logic clk,
  input logic reset,
  ex_issue_stage_if.slave bus
);

  logic              exValid;
  logic [OP_W-1:0]   aluOp;
  logic [REG_W-1:0]  exRd;
  logic              exRegWrite;
  logic              exMemRead;
  logic [REG_W-1:0]  rsReg;
  logic [REG_W-1:0]  rtReg;
  logic              useImm;
  logic [DATA_W-1:0] aVal;
  logic [DATA_W-1:0] bVal;
  logic [31:0]       stallCount;

  logic [DATA_W-1:0] aluA;
  logic [DATA_W-1:0] aluB;
  fwdSel_e           aSel;
  fwdSel_e           bSel;

  logic hz;
  logic idReady;
  logic accept;

  // A load sitting here cannot supply its data to the instruction behind it
  // until it reaches MEM/WB, so a dependent consumer must wait one cycle.
  assign hz = exValid && exMemRead && (exRd != '0) &&
              ((bus.id_rs == exRd) || (!bus.id_use_imm && (bus.id_rt == exRd)));

  assign idReady = !bus.flush && !hz && (!exValid || bus.ex_ready);
  assign accept  = bus.id_valid && idReady;

  operand_forward_mux muxA (
    .storedVal     (aVal),
    .srcReg        (rsReg),
    .enable        (1'b1),
    .exMemRegWrite (bus.ex_mem_reg_write),
    .exMemMemRead  (bus.ex_mem_mem_read),
    .exMemRd       (bus.ex_mem_rd),
    .exMemResult   (bus.ex_mem_result),
    .memWbRegWrite (bus.mem_wb_reg_write),
    .memWbRd       (bus.mem_wb_rd),
    .memWbData     (bus.mem_wb_data),
    .value         (aluA),
    .sel           (aSel)
  );

  operand_forward_mux muxB (
    .storedVal     (bVal),
    .srcReg        (rtReg),
    .enable        (!useImm),
    .exMemRegWrite (bus.ex_mem_reg_write),
    .exMemMemRead  (bus.ex_mem_mem_read),
    .exMemRd       (bus.ex_mem_rd),
    .exMemResult   (bus.ex_mem_result),
    .memWbRegWrite (bus.mem_wb_reg_write),
    .memWbRd       (bus.mem_wb_rd),
    .memWbData     (bus.mem_wb_data),
    .value         (aluB),
    .sel           (bSel)
  );

  // Priority: flush, accept, bubble, drain, hold. While holding, any operand
  // currently being forwarded is captured, because its producer may retire
  // before EX finally takes the instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exValid    <= 1'b0;
      aluOp      <= OP_NOP;
      exRd       <= '0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      rsReg      <= '0;
      rtReg      <= '0;
      useImm     <= 1'b0;
      aVal       <= '0;
      bVal       <= '0;
      stallCount <= '0;
    end else if (bus.flush) begin
      exValid    <= 1'b0;
      aluOp      <= OP_NOP;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
    end else if (accept) begin
      exValid    <= 1'b1;
      aluOp      <= bus.id_op;
      exRd       <= bus.id_rd;
      exRegWrite <= bus.id_reg_write;
      exMemRead  <= bus.id_mem_read;
      rsReg      <= bus.id_rs;
      rtReg      <= bus.id_rt;
      useImm     <= bus.id_use_imm;
      aVal       <= bus.id_rs_data;
      bVal       <= bus.id_use_imm ? bus.id_imm : bus.id_rt_data;
    end else if (hz && bus.ex_ready) begin
      exValid    <= 1'b0;
      aluOp      <= OP_NOP;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      if (stallCount != 32'hFFFF_FFFF) begin
        stallCount <= stallCount + 32'd1;
      end
    end else if (bus.ex_ready) begin
      exValid <= 1'b0;
    end else if (exValid) begin
      if (aSel != FWD_NONE) begin
        aVal <= aluA;
      end
      if (bSel != FWD_NONE) begin
        bVal <= aluB;
      end
    end
  end

  assign bus.id_ready     = idReady;
  assign bus.ex_valid     = exValid;
  assign bus.alu_a        = aluA;
  assign bus.alu_b        = aluB;
  assign bus.alu_op       = aluOp;
  assign bus.ex_rd        = exRd;
  assign bus.ex_reg_write = exRegWrite;
  assign bus.ex_mem_read  = exMemRead;
  assign bus.stall_count  = stallCount;

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX issue stage that sits directly upstream of the ALU. It latches one decoded instruction, resolves operand forwarding from the EX/MEM and MEM/WB stages, and drives the ALU's `a`, `b` and `operation` inputs. It also detects load-use hazards and inserts bubbles, holds under downstream back-pressure, and discards its contents on a branch flush.

## Interface
- `DATA_W`, 32, operand/result width
- `REG_W`, 5, register-number width
- `OP_W`, 6, ALU function-code width
- `clk` in 1: the single clock; all state updates on its rising edge
- `reset` in 1: asynchronous, active-high
- `id_valid` in 1 / `id_ready` out 1: decode-side handshake
- `id_op` in OP_W; `id_rs`, `id_rt`, `id_rd` in REG_W; `id_rs_data`, `id_rt_data`, `id_imm` in DATA_W
- `id_use_imm` in 1: selects `id_imm` as `b`, so `rt` is not a source
- `id_reg_write`, `id_mem_read` in 1: instruction writes `rd` / instruction is a load
- `flush` in 1: kills the stage contents
- `ex_mem_reg_write`, `ex_mem_mem_read` in 1; `ex_mem_rd` in REG_W; `ex_mem_result` in DATA_W
- `mem_wb_reg_write` in 1; `mem_wb_rd` in REG_W; `mem_wb_data` in DATA_W
- `ex_ready` in 1: EX side can accept
- `ex_valid` out 1; `alu_a`, `alu_b` out DATA_W; `alu_op` out OP_W; `ex_rd` out REG_W; `ex_reg_write`, `ex_mem_read` out 1
- `stall_count` out 32: count of load-use bubble cycles, saturating

## Operation
- **Occupancy states:** EMPTY (`ex_valid`=0) and FULL (`ex_valid`=1).
  - FULL with `!ex_ready` is HOLD.
- **Hazard:** `hz` = `ex_valid & ex_mem_read & ex_rd!=0 & (id_rs==ex_rd | (!id_use_imm & id_rt==ex_rd))`.
- **Ready:** `id_ready` = `!flush & !hz & (!ex_valid | ex_ready)`.
- **Accept** (`id_valid & id_ready`): store op, rd, flags and sources.
  - Stored `b` = `id_use_imm ? id_imm : id_rt_data`.
  - Next state is FULL.
- **Bubble:** if `hz & ex_ready & !flush`, load a bubble.
  - Bubble fields: `ex_valid`=0, `alu_op`=6'b000000, `ex_reg_write`=0, `ex_mem_read`=0.
  - `stall_count` increments, saturating at 0xFFFF_FFFF.
- **Drain:** `ex_ready` with no accept and no hazard gives EMPTY.
- **Flush:** dominates accept and bubble. Next cycle `ex_valid`=0 and write flags are 0; nothing is accepted that cycle.
- **Forwarding** (per operand, combinational on stored register numbers):
  - EX/MEM wins when `ex_mem_reg_write & !ex_mem_mem_read & ex_mem_rd!=0 & match`.
  - Else MEM/WB wins when `mem_wb_reg_write & mem_wb_rd!=0 & match`.
  - Else the stored value is used.
  - `b` is never forwarded when the stored `use_imm`=1.
  - Register 0 is never forwarded.
- **HOLD refresh:** every HOLD cycle, write the forwarded `alu_a`/`alu_b` back into the stored operands, so a value is not lost when its producer retires.

## Timing
- **Latency:** 1 cycle from accept to `ex_valid`/`alu_op`/`ex_rd`.
- **`alu_a`/`alu_b`:** combinational from the stored operands plus the forwarding inputs, valid in the same cycle as `ex_valid`.
- **`id_ready`:** combinational; no registered path from `id_valid` to `id_ready`.
- **Reset values (async):**
  - `ex_valid`=0, `alu_op`=0, `ex_rd`=0, `ex_reg_write`=0, `ex_mem_read`=0
  - stored operands = 0, so `alu_a`=`alu_b`=0 with no forwarding active
  - `stall_count`=0
- **Reset mid-HOLD:** the instruction is dropped; there is no replay.
- **Load-use cost:** exactly one bubble per hazard. The dependent is accepted the cycle after the load leaves, while the load sits in EX/MEM. It then forwards from MEM/WB on the following cycle.
- **Hazard during HOLD:** `id_ready`=0 already; `stall_count` does not increment.

## Structure
- **Shared package:**
  - `OP_W`, `REG_W`, `DATA_W` constants
  - ALU function-code constants: `OP_NOP`=6'b000000, `OP_ADD`=6'b100000, `OP_SUB`=6'b100010, `OP_AND`=6'b100100, `OP_OR`=6'b100101
  - forward-select enum {`FWD_NONE`, `FWD_EXMEM`, `FWD_MEMWB`}
- **Sub-module:** `operand_forward_mux`, instantiated twice (`a`, `b`). It takes the stored value, source register, an `enable`, and both forward ports, and returns the value plus the select.
- **Top:** pipeline register, hazard logic, HOLD refresh and counter.

## Test plan
- **Basic issue:** reset, then accept add with rs_data=5, rt_data=7 -> next cycle `ex_valid`=1, `alu_a`=5, `alu_b`=7, `alu_op`=6'b100000.
- **Forward priority:** stored rs=3; ex_mem rd=3, result 0x10; mem_wb rd=3, data 0x20.
  - -> `alu_a`=0x10
  - with `ex_mem_reg_write`=0 -> 0x20
  - with rs=0 -> stored value
- **Load-use:** stage holds lw rd=4, `ex_ready`=1; id presents add rs=4.
  - -> `id_ready`=0 for 1 cycle, then a bubble with `ex_valid`=0, and `stall_count` 0->1.
  - -> The add is then accepted; one cycle later, with mem_wb rd=4, data 0xAB, `alu_a`=0xAB.
- **HOLD refresh:** `ex_ready`=0 for 3 cycles; mem_wb forwards 0x55 to rs in cycle 1 only -> `alu_a`=0x55 in all 3 cycles.
- **Flush:** `flush`=1 with `id_valid`=1 while FULL -> `id_ready`=0; next cycle `ex_valid`=0, `ex_reg_write`=0.
- **Async reset mid-operation:** assert `reset` between edges while FULL -> `ex_valid`=0 and `alu_a`=0 immediately, before the next edge.
